// File: rtl/conv_out_buffer.sv
// conv_out_buffer: optional ReLU plus saturation of accumulator results into a small FIFO,
// with a one-cycle pulse after the last output of each frame is popped.
module conv_out_buffer #(
  parameter int IN_WIDTH  = 20,
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH     = 8,
  parameter int Y_COUNT   = 64,
  parameter int RELU      = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [IN_WIDTH-1:0]  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic signed [OUT_WIDTH-1:0] m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        frame_done,
  output logic [7:0]                  sat_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(Y_COUNT + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [FW-1:0] LAST = FW'(Y_COUNT - 1);
  localparam logic signed [IN_WIDTH-1:0] MAX = {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] MIN = ~MAX;

  logic signed [OUT_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [FW-1:0] frm_q, frm_d;
  logic done_q, done_d;
  logic [7:0] sat_q, sat_d;
  logic signed [IN_WIDTH-1:0] v;
  logic signed [OUT_WIDTH-1:0] w;
  logic hi, lo, push, pop;

  assign s_ready    = (cnt_q != FULL) && !reset;
  assign m_valid    = cnt_q != '0;
  assign m_data     = mem_q[rd_q];
  assign frame_done = done_q;
  assign sat_count  = sat_q;

  always_comb begin
    push   = s_valid && s_ready;
    pop    = m_valid && m_ready;
    v      = (RELU != 0 && s_data[IN_WIDTH-1]) ? '0 : s_data;
    hi     = v > MAX;
    lo     = v < MIN;
    w      = hi ? MAX[OUT_WIDTH-1:0] : lo ? MIN[OUT_WIDTH-1:0] : v[OUT_WIDTH-1:0];
    wr_d   = push ? wr_q + AW'(1) : wr_q;
    rd_d   = pop ? rd_q + AW'(1) : rd_q;
    cnt_d  = (push && !pop) ? cnt_q + (AW+1)'(1) : (pop && !push) ? cnt_q - (AW+1)'(1) : cnt_q;
    frm_d  = pop ? ((frm_q == LAST) ? '0 : frm_q + FW'(1)) : frm_q;
    done_d = pop && (frm_q == LAST);
    sat_d  = (push && (hi || lo) && sat_q != 8'hff) ? sat_q + 8'd1 : sat_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      frm_q  <= '0;
      done_q <= 1'b0;
      sat_q  <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      frm_q  <= frm_d;
      done_q <= done_d;
      sat_q  <= sat_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= w;
  end
endmodule

// File: tb/tb_conv_out_buffer.sv
// tb_conv_out_buffer: two instances (RELU off/on, Y_COUNT=4) share stimulus and are
// compared each cycle against a queue-based reference model.
module tb_conv_out_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [19:0] s_data = '0;
  logic s_valid = 1'b0;
  logic m_ready = 1'b0;
  logic s_ready0, s_ready1, m_valid0, m_valid1, fd0, fd1;
  logic signed [15:0] m_data0, m_data1;
  logic [7:0] sat0_o, sat1_o;

  always #5 clk = ~clk;

  conv_out_buffer #(.IN_WIDTH(20), .OUT_WIDTH(16), .DEPTH(8), .Y_COUNT(4), .RELU(0)) u0 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready0),
    .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready), .frame_done(fd0), .sat_count(sat0_o));
  conv_out_buffer #(.IN_WIDTH(20), .OUT_WIDTH(16), .DEPTH(8), .Y_COUNT(4), .RELU(1)) u1 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready), .frame_done(fd1), .sat_count(sat1_o));

  int checks = 0, errors = 0;
  int q0[$], q1[$], outlog[$];
  int pops = 0, sat0 = 0, sat1 = 0, frames = 0, pushes = 0, maxocc = 0;
  bit done_e = 0;

  typedef struct {int d; int e0; int e1; bit c0; bit c1;} vec_t;
  vec_t tbl[12];

  task automatic chk(string n, int a, int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  function automatic int xf(int x, bit relu, output bit c);
    int v;
    v = (relu && x < 0) ? 0 : x;
    c = 1'b0;
    if (v > 32767) begin v = 32767; c = 1'b1; end
    else if (v < -32768) begin v = -32768; c = 1'b1; end
    return v;
  endfunction

  task automatic check_all();
    chk("s_ready0", int'(s_ready0), int'(!reset && q0.size() < 8));
    chk("s_ready1", int'(s_ready1), int'(!reset && q1.size() < 8));
    chk("m_valid0", int'(m_valid0), int'(q0.size() != 0));
    chk("m_valid1", int'(m_valid1), int'(q1.size() != 0));
    if (q0.size() != 0) chk("m_data0", int'(m_data0), q0[0]);
    if (q1.size() != 0) chk("m_data1", int'(m_data1), q1[0]);
    chk("frame_done0", int'(fd0), int'(done_e));
    chk("frame_done1", int'(fd1), int'(done_e));
    chk("sat_count0", int'(sat0_o), sat0);
    chk("sat_count1", int'(sat1_o), sat1);
  endtask

  task automatic tick();
    bit push, pop, c;
    int x;
    push = s_valid && !reset && q0.size() < 8;
    pop = m_ready && q0.size() != 0;
    x = int'(s_data);
    @(posedge clk);
    done_e = 1'b0;
    if (reset) begin
      q0.delete(); q1.delete();
      pops = 0; sat0 = 0; sat1 = 0;
    end else begin
      if (pop) begin
        outlog.push_back(q0[0]);
        void'(q0.pop_front());
        void'(q1.pop_front());
        pops++;
        if (pops % 4 == 0) begin done_e = 1'b1; frames++; end
      end
      if (push) begin
        pushes++;
        q0.push_back(xf(x, 1'b0, c));
        if (c && sat0 < 255) sat0++;
        q1.push_back(xf(x, 1'b1, c));
        if (c && sat1 < 255) sat1++;
      end
    end
    if (q0.size() > maxocc) maxocc = q0.size();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int r, sum0, sum1;
    tbl[0]  = '{100, 100, 100, 0, 0};
    tbl[1]  = '{40000, 32767, 32767, 1, 1};
    tbl[2]  = '{-40000, -32768, 0, 1, 0};
    tbl[3]  = '{-5, -5, 0, 0, 0};
    tbl[4]  = '{-7, -7, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0};
    tbl[6]  = '{9, 9, 9, 0, 0};
    tbl[7]  = '{-50000, -32768, 0, 1, 0};
    tbl[8]  = '{32767, 32767, 32767, 0, 0};
    tbl[9]  = '{32768, 32767, 32767, 1, 1};
    tbl[10] = '{-32768, -32768, 0, 0, 0};
    tbl[11] = '{-32769, -32768, 0, 1, 0};

    // reset state
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // table: push one, check narrowed value held under back-pressure, then pop it
    sum0 = 0; sum1 = 0;
    foreach (tbl[i]) begin
      s_valid = 1'b1; s_data = 20'(tbl[i].d); m_ready = 1'b0;
      tick();
      s_valid = 1'b0;
      tick();
      chk("tbl_relu0", int'(m_data0), tbl[i].e0);
      chk("tbl_relu1", int'(m_data1), tbl[i].e1);
      chk("tbl_valid", int'(m_valid0), 1);
      sum0 += tbl[i].c0; sum1 += tbl[i].c1;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("tbl_empty", int'(m_valid0), 0);
    end
    chk("tbl_sat0", int'(sat0_o), sum0);
    chk("tbl_sat1", int'(sat1_o), sum1);

    // fill to full under back-pressure, then drain
    reset = 1'b1; tick(); reset = 1'b0;
    pushes = 0; m_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      s_valid = 1'b1; s_data = 20'(i);
      tick();
    end
    s_valid = 1'b0;
    chk("full_accepted", pushes, 8);
    chk("full_s_ready", int'(s_ready0), 0);
    outlog.delete();
    m_ready = 1'b1;
    tick();
    chk("ready_after_pop", int'(s_ready0), 1);
    for (int i = 0; i < 8; i++) tick();
    chk("drain_count", outlog.size(), 8);
    for (int i = 0; i < outlog.size() && i < 8; i++) chk("drain_order", outlog[i], i + 1);
    m_ready = 1'b0;

    // streaming with frames of 4
    reset = 1'b1; tick(); reset = 1'b0;
    frames = 0; maxocc = 0; outlog.delete(); m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 20'(i + 11);
      tick();
    end
    s_valid = 1'b0;
    tick(); tick();
    chk("stream_maxocc", maxocc, 1);
    chk("stream_frames", frames, 2);
    chk("stream_count", outlog.size(), 10);
    for (int i = 0; i < outlog.size() && i < 10; i++) chk("stream_order", outlog[i], i + 11);
    m_ready = 1'b0;

    // reset mid-operation discards data, counters and partial frame
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = (i == 2) ? 20'sd40000 : 20'(i + 50);
      tick();
    end
    m_ready = 1'b1; s_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    chk("rst_m_valid", int'(m_valid0), 0);
    chk("rst_sat", int'(sat0_o), 0);
    frames = 0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 20'(3 + i);
      tick();
      if (i == 0) chk("rst_first_out", int'(m_data0), 3);
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_frame_realigned", frames, 1);

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 2);
      if (r == 0) s_data = 20'($urandom_range(0, 200) - 100);
      else if (r == 1) s_data = 20'(($urandom_range(0, 1) ? 1 : -1) * (32760 + $urandom_range(0, 20)));
      else s_data = 20'($urandom);
      tick();
    end
    reset = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_out_buffer.md
Name: conv_out_buffer

Overview:
- Output stage directly downstream of the convolution control/MAC datapath.
- Accepts each accumulated result y from the datapath over a valid/ready handshake.
- Optionally applies ReLU, then saturates the wide accumulator value to the narrower output width.
- Buffers results in a small FIFO so a stalled consumer does not stall the MAC, and flags the end of each output frame.

Parameters:
- IN_WIDTH, 20: signed width of incoming accumulator result (matches MAC OUT_WIDTH).
- OUT_WIDTH, 16: signed width of emitted result; must be <= IN_WIDTH.
- DEPTH, 8: FIFO entries; power of two, >= 2.
- Y_COUNT, 64: outputs per frame (X_LEN - F_LEN + 1 of upstream).
- RELU, 0: 1 = clamp negative inputs to 0 before saturation.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_data  in  IN_WIDTH  signed result from datapath.
- s_valid  in  1  s_data valid.
- s_ready  out  1  buffer can accept this cycle.
- m_data  out  OUT_WIDTH  signed result to consumer.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts this cycle.
- frame_done  out  1  one-cycle pulse on the pop of the Y_COUNT-th output of a frame.
- sat_count  out  8  count of samples clipped by saturation; holds at 255.

Behaviour:
- Clock and reset: reset and clk are as stated in Ports; everything updates on posedge clk.
- State: register array mem[DEPTH], wr_ptr/rd_ptr of log2(DEPTH) bits, occupancy count of log2(DEPTH)+1 bits, frame counter of clog2(Y_COUNT+1) bits, sat_count.
- Reset values (while reset high and on the cycle after):
  - pointers, occupancy, frame counter = 0; frame_done = 0; sat_count = 0.
  - m_valid = 0; s_ready = 0 while reset asserted, then 1.
  - m_data is don't-care while m_valid = 0.
- Reset mid-operation: all buffered data is discarded; no frame_done is emitted.
- Handshake: push = s_valid && s_ready; pop = m_valid && m_ready.
  - s_ready = (occupancy != DEPTH) && !reset, derived only from registers and reset, with no combinational path from s_valid.
  - m_valid = (occupancy != 0).
  - m_data = mem[rd_ptr], a combinational read of the registered array.
- Latency: a sample pushed in cycle N is visible with m_valid = 1 in cycle N+1. There is no bypass.
- Transform (applied at push, stored already narrowed):
  - v = (RELU && s_data < 0) ? 0 : s_data.
  - If v > 2^(OUT_WIDTH-1)-1, store 2^(OUT_WIDTH-1)-1 and mark the sample clipped.
  - If v < -2^(OUT_WIDTH-1), store -2^(OUT_WIDTH-1) and mark the sample clipped.
  - Otherwise store v[OUT_WIDTH-1:0].
  - ReLU zeroing alone is not counted as clipping.
- sat_count increments by 1 on each push of a clipped sample; it saturates at 255.
- Occupancy update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Full (occupancy == DEPTH): s_ready = 0, so a push cannot occur. A pop in this cycle frees a slot, which becomes visible as s_ready = 1 in the next cycle.
- Empty: m_valid = 0, so no pop. A simultaneous push makes the data valid in the next cycle.
- Pointers wrap modulo DEPTH with no gap.
- Frame counter:
  - increments on each pop.
  - On the pop where counter == Y_COUNT-1: the counter returns to 0 and frame_done = 1 for the following cycle only.
  - Frames are back-to-back with no idle requirement.
- m_valid and m_data hold stable while m_valid && !m_ready. Data is never dropped or duplicated.

Test Plan:
- Reset then single push: hold m_ready = 0, push s_data = 100 -> m_valid = 1 next cycle, m_data = 100; it holds until m_ready = 1, then m_valid = 0; sat_count = 0.
- Saturation (IN 20, OUT 16):
  - push 40000 -> m_data = 32767.
  - push -40000 -> m_data = -32768.
  - push -5 -> m_data = -5.
  - sat_count = 2 afterwards.
- ReLU: RELU = 1, push -7, 0, 9 and -50000 -> outputs 0, 0, 9, 0; sat_count = 0.
- Full/back-pressure: m_ready = 0, s_valid = 1 continuously with values 1..10 -> exactly 8 accepted and s_ready = 0 after the 8th. Then m_ready = 1 -> outputs 1..8 in order, and s_ready returns to 1 one cycle after the first pop.
- Streaming and frames: Y_COUNT = 4, s_valid = m_ready = 1 for 10 samples -> occupancy stays <= 1, frame_done pulses after the 4th and 8th pops only, and no sample is lost.
- Reset mid-operation: 5 entries buffered, assert reset for 1 cycle -> m_valid = 0, frame counter = 0, sat_count = 0. The next pushed value 3 appears as the first output.
